toast_wb_unit: RTL and testbench



---
 rtl/toast_wb_unit.sv | 167 ++++++++++++++++
 tb/tb_toast_wb_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/toast_wb_unit.sv
// toast_wb_unit: writeback stage owning the register-file write port.
// In-order pending queue, load response pairing, load formatting, instret.
module toast_wb_unit #(
    parameter int REG_DATA_WIDTH     = 32,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int QUEUE_DEPTH        = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          mem_valid_i,
    output logic                          mem_ready_o,
    input  logic [REGFILE_ADDR_WIDTH-1:0] mem_rd_addr_i,
    input  logic                          mem_rd_wr_i,
    input  logic                          mem_is_load_i,
    input  logic [2:0]                    mem_load_type_i,
    input  logic [1:0]                    mem_byte_off_i,
    input  logic [REG_DATA_WIDTH-1:0]     mem_result_i,
    input  logic                          dmem_rvalid_i,
    input  logic [REG_DATA_WIDTH-1:0]     dmem_rdata_i,
    output logic [REGFILE_ADDR_WIDTH-1:0] rd_addr_o,
    output logic [REG_DATA_WIDTH-1:0]     rd_wr_data_o,
    output logic                          rd_wr_en_o,
    output logic [63:0]                   instret_o,
    output logic                          busy_o,
    output logic                          err_o
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    typedef struct packed {
        logic [REGFILE_ADDR_WIDTH-1:0] rd_addr;
        logic                          rd_wr;
        logic                          is_load;
        logic [2:0]                    load_type;
        logic [1:0]                    byte_off;
        logic [REG_DATA_WIDTH-1:0]     result;
    } entry_t;

    entry_t                          q_q [QUEUE_DEPTH];
    logic [PW-1:0]                   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]                   count_q, count_d;
    logic                            buf_full_q, buf_full_d;
    logic [REG_DATA_WIDTH-1:0]       buf_data_q, buf_data_d;
    logic [REGFILE_ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [REG_DATA_WIDTH-1:0]       rd_data_q, rd_data_d;
    logic                            rd_en_q, rd_en_d;
    logic [63:0]                     instret_q;
    logic                            err_q, err_d;

    entry_t                          head;
    logic                            push, pop, use_buf, use_live;
    logic                            any_load, cap_evt, resp_err, bad_type, wr;
    logic [REG_DATA_WIDTH-1:0]       raw, wdata;

    // Raw aligned word to formatted register value
    function automatic logic [31:0] fmt(input logic [31:0] w,
                                        input logic [2:0]  t,
                                        input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (t)
            3'b000:  fmt = {{24{b[7]}}, b};
            3'b001:  fmt = {{16{h[15]}}, h};
            3'b100:  fmt = {24'b0, b};
            3'b101:  fmt = {16'b0, h};
            default: fmt = w;
        endcase
    endfunction

    assign mem_ready_o = !reset_i && (count_q != CW'(QUEUE_DEPTH));
    assign push        = mem_valid_i && mem_ready_o;
    assign busy_o      = (count_q != '0) || buf_full_q;
    assign rd_addr_o    = rd_addr_q;
    assign rd_wr_data_o = rd_data_q;
    assign rd_wr_en_o   = rd_en_q;
    assign instret_o    = instret_q;
    assign err_o        = err_q;

    // Retire decision at the head: buffered response beats a live one
    always_comb begin
        head     = q_q[rd_ptr_q];
        pop      = 1'b0;
        use_buf  = 1'b0;
        use_live = 1'b0;
        raw      = buf_data_q;
        if (count_q != '0) begin
            if (!head.is_load) begin
                pop = 1'b1;
            end else if (buf_full_q) begin
                pop     = 1'b1;
                use_buf = 1'b1;
            end else if (dmem_rvalid_i) begin
                pop      = 1'b1;
                use_live = 1'b1;
                raw      = dmem_rdata_i;
            end
        end
    end

    // Does any pending entry still expect a response
    always_comb begin
        any_load = 1'b0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (CW'(i) < count_q && q_q[rd_ptr_q + PW'(i)].is_load)
                any_load = 1'b1;
        end
    end

    // Response buffering, formatting, write-port and error next state
    always_comb begin
        cap_evt  = dmem_rvalid_i && !use_live;
        resp_err = cap_evt && (buf_full_q || !any_load);
        bad_type = !(head.load_type inside {3'b000, 3'b001, 3'b010,
                                            3'b100, 3'b101});
        buf_full_d = buf_full_q && !use_buf;
        buf_data_d = buf_data_q;
        if (cap_evt && !resp_err) begin
            buf_full_d = 1'b1;
            buf_data_d = dmem_rdata_i;
        end
        wdata = head.is_load ? fmt(raw, head.load_type, head.byte_off)
                             : head.result;
        wr        = pop && head.rd_wr && (head.rd_addr != '0);
        rd_en_d   = wr;
        rd_addr_d = wr ? head.rd_addr : '0;
        rd_data_d = wr ? wdata : '0;
        err_d     = err_q || resp_err || (pop && head.is_load && bad_type);
        count_d   = count_q + CW'(push) - CW'(pop);
    end

    // State update with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) q_q[i] <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            buf_full_q <= 1'b0;
            buf_data_q <= '0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            rd_en_q    <= 1'b0;
            instret_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            if (push) begin
                q_q[wr_ptr_q] <= '{mem_rd_addr_i, mem_rd_wr_i, mem_is_load_i,
                                   mem_load_type_i, mem_byte_off_i,
                                   mem_result_i};
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                instret_q <= instret_q + 64'd1;
            end
            count_q    <= count_d;
            buf_full_q <= buf_full_d;
            buf_data_q <= buf_data_d;
            rd_addr_q  <= rd_addr_d;
            rd_data_q  <= rd_data_d;
            rd_en_q    <= rd_en_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_toast_wb_unit.sv
// Bench for toast_wb_unit: directed cases plus random traffic
// checked cycle by cycle against a transaction-level queue model.
module tb_toast_wb_unit;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mv = 1'b0, wr = 1'b0, ld = 1'b0, rv = 1'b0;
    logic [4:0]  rd = '0;
    logic [2:0]  lt = '0;
    logic [1:0]  off = '0;
    logic [31:0] res = '0, rdata = '0;
    logic        ready, wen, busy, err;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [63:0] instret;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        int          rd;
        bit          wr;
        bit          ld;
        int          t;
        int          off;
        bit [31:0]   res;
    } ent_t;

    ent_t        pq[$];
    bit          bufv;
    bit [31:0]   bufd;
    bit [63:0]   m_instret;
    bit          m_err;
    bit          e_wen;
    int          e_addr;
    bit [31:0]   e_data;

    toast_wb_unit dut (
        .clk_i(clk), .reset_i(rst),
        .mem_valid_i(mv), .mem_ready_o(ready),
        .mem_rd_addr_i(rd), .mem_rd_wr_i(wr), .mem_is_load_i(ld),
        .mem_load_type_i(lt), .mem_byte_off_i(off), .mem_result_i(res),
        .dmem_rvalid_i(rv), .dmem_rdata_i(rdata),
        .rd_addr_o(waddr), .rd_wr_data_o(wdata), .rd_wr_en_o(wen),
        .instret_o(instret), .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] fmt_ref(bit [31:0] w, int t, int o);
        int b, h;
        b = int'((w >> (o * 8)) & 32'hFF);
        h = int'((w >> ((o / 2) * 16)) & 32'hFFFF);
        if (t == 0) return bit'(b >= 128) ? 32'(b - 256) : 32'(b);
        if (t == 1) return bit'(h >= 32768) ? 32'(h - 65536) : 32'(h);
        if (t == 4) return 32'(b);
        if (t == 5) return 32'(h);
        return w;
    endfunction

    // One clock: advance the model, then compare after the edge
    task automatic step();
        ent_t h;
        bit ret = 0, used = 0, usebuf = 0, rdy, hasld = 0, oldv;
        bit [31:0] raw = '0;
        rdy = !rst && pq.size() < D;
        e_wen = 0; e_addr = 0; e_data = 0;
        if (rst) begin
            pq.delete(); bufv = 0; bufd = 0; m_instret = 0; m_err = 0;
        end else begin
            if (pq.size() > 0) begin
                h = pq[0];
                if (!h.ld) ret = 1;
                else if (bufv) begin ret = 1; raw = bufd; usebuf = 1; end
                else if (rv) begin ret = 1; raw = rdata; used = 1; end
            end
            foreach (pq[i]) if (pq[i].ld) hasld = 1;
            oldv = bufv;
            if (usebuf) bufv = 0;
            if (rv && !used) begin
                if (oldv || !hasld) m_err = 1;
                else begin bufv = 1; bufd = rdata; end
            end
            if (ret) begin
                void'(pq.pop_front());
                m_instret++;
                if (h.ld && !(h.t inside {0, 1, 2, 4, 5})) m_err = 1;
                if (h.wr && h.rd != 0) begin
                    e_wen = 1; e_addr = h.rd;
                    e_data = h.ld ? fmt_ref(raw, h.t, h.off) : h.res;
                end
            end
            if (mv && rdy)
                pq.push_back('{int'(rd), wr, ld, int'(lt), int'(off), res});
        end
        @(posedge clk);
        #1;
        chk("wen", wen, e_wen);
        chk("waddr", waddr, e_addr);
        chk("wdata", wdata, e_data);
        chk("instret", instret, m_instret);
        chk("err", err, m_err);
        chk("ready", ready, !rst && pq.size() < D);
        chk("busy", busy, pq.size() > 0 || bufv);
    endtask

    task automatic do_reset();
        mv = 0; rv = 0; rst = 1;
        step();
        rst = 0;
    endtask

    task automatic push(input bit l, input int r, input int t,
                        input int o, input bit [31:0] v);
        mv = 1; ld = l; wr = 1; rd = 5'(r); lt = 3'(t); off = 2'(o); res = v;
        step();
        mv = 0;
    endtask

    task automatic ld_test(input int t, input int o, input bit [31:0] exp);
        do_reset();
        push(1, 7, t, o, 32'h0);
        rv = 1; rdata = 32'h8000_BEEF;
        step();
        rv = 0;
        chk("ld_fmt", wdata, exp);
    endtask

    initial begin
        do_reset();
        chk("rst_ready", ready, 0);
        step();
        // non-load to x5
        push(0, 5, 0, 0, 32'h0000_1234);
        step();
        chk("nl_en", wen, 1);
        chk("nl_addr", waddr, 5);
        chk("nl_data", wdata, 32'h1234);
        chk("nl_instret", instret, 1);
        // write to x0 is suppressed but counted
        do_reset();
        push(0, 0, 0, 0, 32'hFFFF_FFFF);
        step();
        chk("x0_en", wen, 0);
        chk("x0_instret", instret, 1);
        // load formatting
        ld_test(0, 3, 32'hFFFF_FF80);
        ld_test(4, 3, 32'h0000_0080);
        ld_test(5, 0, 32'h0000_BEEF);
        ld_test(1, 0, 32'hFFFF_BEEF);
        ld_test(1, 3, 32'hFFFF_8000);
        ld_test(2, 1, 32'h8000_BEEF);
        ld_test(3, 0, 32'h8000_BEEF);
        chk("badtype_err", err, 1);
        // fill with loads, then drain with back-to-back responses
        do_reset();
        for (int i = 1; i <= 4; i++) push(1, i, 2, 0, 32'h0);
        chk("full_ready", ready, 0);
        chk("full_busy", busy, 1);
        for (int i = 1; i <= 4; i++) begin
            rv = 1; rdata = 32'(i * 32'h1111);
            step();
            chk("drain_addr", waddr, i);
        end
        rv = 0;
        chk("drain_ready", ready, 1);
        // response arriving while a non-load retires is buffered
        do_reset();
        push(1, 1, 2, 0, 32'h0);
        push(0, 2, 0, 0, 32'h22);
        push(1, 3, 2, 0, 32'h0);
        rv = 1; rdata = 32'hAAAA_0001; step();
        rv = 1; rdata = 32'hBBBB_0003; step();
        chk("buf_nl_data", wdata, 32'h22);
        rv = 0; step();
        chk("buf_ld_addr", waddr, 3);
        chk("buf_ld_data", wdata, 32'hBBBB_0003);
        chk("buf_err", err, 0);
        // spurious response, then reset with entries pending
        do_reset();
        rv = 1; rdata = 32'h1; step();
        rv = 0;
        chk("spur_err", err, 1);
        chk("spur_en", wen, 0);
        push(1, 4, 2, 0, 32'h0);
        push(1, 6, 2, 0, 32'h0);
        step();
        chk("sticky_err", err, 1);
        rst = 1; step();
        chk("rst_en", wen, 0);
        chk("rst_data", wdata, 0);
        chk("rst_instret", instret, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        rst = 0;
        // random traffic
        for (int n = 0; n < 600; n++) begin
            int outst;
            outst = 0;
            foreach (pq[i]) if (pq[i].ld) outst++;
            if (bufv) outst--;
            mv = 1'($urandom_range(0, 1));
            ld = 1'($urandom_range(0, 1));
            wr = ($urandom_range(0, 4) != 0);
            rd = 5'($urandom);
            lt = ($urandom_range(0, 30) == 0) ? 3'($urandom)
                 : 3'(($urandom_range(0, 1) * 4) + $urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) lt = 3'd2;
            off = 2'($urandom);
            res = $urandom;
            rdata = $urandom;
            rv = (outst > 0 && $urandom_range(0, 2) != 0)
                 || ($urandom_range(0, 80) == 0);
            if (n % 150 == 0) begin
                rst = 1; step(); rst = 0;
            end else begin
                step();
            end
        end
        mv = 0; rv = 0;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
